// File: rtl/ssd_bcd_formatter.sv
// Sequential binary-to-BCD front end for the 2-digit display (saturates at 99); SSD_BCD_DWELL_EN adds a rate limit.
// Latency: acceptance edge to new digits/o_update is 10 cycles; o_ready is low while busy, and a new sample is never queued.
module ssd_bcd_formatter #(
    parameter int unsigned DWELL_CYCLES = 2000000
) (
    input  logic       i_clk_20mhz,
    input  logic       i_rstn_20mhz,
    input  logic [7:0] i_value,
    input  logic       i_valid,
    output logic       o_ready,
    output logic [3:0] o_value0,
    output logic [3:0] o_value1,
    output logic       o_ovf,
    output logic       o_update
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_LOAD  = 2'd2,
        S_DWELL = 2'd3
    } state_t;

    if (DWELL_CYCLES < 1) begin : g_bad_dwell
        $error("DWELL_CYCLES must be at least 1");
    end

    state_t      state_q, state_d;
    logic [7:0]  bin_q, bin_d;
    logic [11:0] bcd_q, bcd_d;
    logic [11:0] bcd_adj;
    logic [2:0]  cnt_q, cnt_d;
    logic        pend_q, pend_d;
    logic [3:0]  val0_q, val0_d;
    logic [3:0]  val1_q, val1_d;
    logic        ovf_q, ovf_d;
    logic        upd_q, upd_d;

`ifdef SSD_BCD_DWELL_EN
    localparam int unsigned DW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES) : 1;
    logic [DW-1:0] dwell_q, dwell_d;
`endif

    function automatic logic [3:0] add3(input logic [3:0] n);
        return (n >= 4'd5) ? n + 4'd3 : n;
    endfunction

    assign bcd_adj = {add3(bcd_q[11:8]), add3(bcd_q[7:4]), add3(bcd_q[3:0])};

    always_comb begin
        state_d = state_q;
        bin_d   = bin_q;
        bcd_d   = bcd_q;
        cnt_d   = cnt_q;
        pend_d  = 1'b0;
`ifdef SSD_BCD_DWELL_EN
        dwell_d = dwell_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_valid) begin
                    state_d = S_SHIFT;
                    bin_d   = i_value;
                    bcd_d   = 12'd0;
                    cnt_d   = 3'd0;
                end
            end
            S_SHIFT: begin
                {bcd_d, bin_d} = {bcd_adj, bin_q} << 1;
                cnt_d          = cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    state_d = S_LOAD;
                end
            end
            S_LOAD: begin
                // bcd_q stays frozen after LOAD, so the output stage reads it one cycle later
                pend_d = 1'b1;
`ifdef SSD_BCD_DWELL_EN
                state_d = S_DWELL;
                dwell_d = DW'(DWELL_CYCLES - 1);
`else
                state_d = S_IDLE;
`endif
            end
`ifdef SSD_BCD_DWELL_EN
            S_DWELL: begin
                if (dwell_q == '0) begin
                    state_d = S_IDLE;
                end else begin
                    dwell_d = dwell_q - 1'b1;
                end
            end
`endif
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        val0_d = val0_q;
        val1_d = val1_q;
        ovf_d  = ovf_q;
        upd_d  = pend_q;
        if (pend_q) begin
            if (bcd_q[11:8] != 4'd0) begin
                val1_d = 4'd9;
                val0_d = 4'd9;
                ovf_d  = 1'b1;
            end else begin
                val1_d = bcd_q[7:4];
                val0_d = bcd_q[3:0];
                ovf_d  = 1'b0;
            end
        end
    end

    always_ff @(posedge i_clk_20mhz or negedge i_rstn_20mhz) begin
        if (!i_rstn_20mhz) begin
            state_q <= S_IDLE;
            bin_q   <= 8'd0;
            bcd_q   <= 12'd0;
            cnt_q   <= 3'd0;
            pend_q  <= 1'b0;
            val0_q  <= 4'd0;
            val1_q  <= 4'd0;
            ovf_q   <= 1'b0;
            upd_q   <= 1'b0;
`ifdef SSD_BCD_DWELL_EN
            dwell_q <= '0;
`endif
        end else begin
            state_q <= state_d;
            bin_q   <= bin_d;
            bcd_q   <= bcd_d;
            cnt_q   <= cnt_d;
            pend_q  <= pend_d;
            val0_q  <= val0_d;
            val1_q  <= val1_d;
            ovf_q   <= ovf_d;
            upd_q   <= upd_d;
`ifdef SSD_BCD_DWELL_EN
            dwell_q <= dwell_d;
`endif
        end
    end

    assign o_ready  = (state_q == S_IDLE);
    assign o_value0 = val0_q;
    assign o_value1 = val1_q;
    assign o_ovf    = ovf_q;
    assign o_update = upd_q;

endmodule
